// File: rtl/multiword_adder_sequencer.sv
// Wide add/subtract built from one WORD_WIDTH-bit adder slice reused over NUM_WORDS cycles,
// with the inter-word carry held in a register and valid/ready handshakes on both sides.
module multiword_adder_sequencer #(
  parameter int WORD_WIDTH = 8,
  parameter int NUM_WORDS  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WORD_WIDTH*NUM_WORDS-1:0]  in_a,
  input  logic [WORD_WIDTH*NUM_WORDS-1:0]  in_b,
  input  logic                             in_carry,
  input  logic                             in_sub,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WORD_WIDTH*NUM_WORDS-1:0]  out_sum,
  output logic                             out_carry,
  output logic                             busy
);

  localparam int TW   = WORD_WIDTH * NUM_WORDS;
  localparam int IDXW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state;
  logic [TW-1:0]         a_reg;
  logic [TW-1:0]         b_reg;
  logic                  carry_reg;
  logic [IDXW-1:0]       idx;
  logic [WORD_WIDTH-1:0] a_word;
  logic [WORD_WIDTH-1:0] b_word;
  logic [WORD_WIDTH:0]   slice;

  // The single shared adder slice; the carry-in comes from the previous word.
  always_comb begin
    a_word = a_reg[int'(idx)*WORD_WIDTH +: WORD_WIDTH];
    b_word = b_reg[int'(idx)*WORD_WIDTH +: WORD_WIDTH];
    slice  = {1'b0, a_word} + {1'b0, b_word} + {{WORD_WIDTH{1'b0}}, carry_reg};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_sum   <= '0;
      out_carry <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= in_a;
            b_reg     <= in_sub ? ~in_b : in_b;
            carry_reg <= in_carry;
            idx       <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          out_sum[int'(idx)*WORD_WIDTH +: WORD_WIDTH] <= slice[WORD_WIDTH-1:0];
          carry_reg <= slice[WORD_WIDTH];
          if (idx == LAST_IDX) begin
            out_carry <= slice[WORD_WIDTH];
            out_valid <= 1'b1;
            idx       <= '0;
            state     <= DONE;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        DONE: begin
          // Result stays put until the consumer takes it.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
